pkt_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single XGE MAC transmit packet interface (pkt_tx_*) between NUM_SRC independent packet sources. It sits directly in front of the MAC TX FIFO write port. Once a source is granted, the grant is held from its sop beat through its eop beat, so packets are never interleaved. Backpressure follows pkt_tx_full, and every beat is registered once on its way to the MAC.

---
 rtl/pkt_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_pkt_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC pkt_tx_* write port among NUM_SRC sources.
// A grant is held from sop through eop; every forwarded beat is registered once.
module pkt_tx_arbiter #(
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,
  input  logic [NUM_SRC*64-1:0] src_tx_data,
  input  logic [NUM_SRC-1:0]    src_tx_val,
  input  logic [NUM_SRC-1:0]    src_tx_sop,
  input  logic [NUM_SRC-1:0]    src_tx_eop,
  input  logic [NUM_SRC*3-1:0]  src_tx_mod,
  output logic [NUM_SRC-1:0]    src_tx_rdy,
  output logic [63:0]           pkt_tx_data,
  output logic                  pkt_tx_val,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic [2:0]            pkt_tx_mod,
  input  logic                  pkt_tx_full,
  output logic [NUM_SRC-1:0]    arb_grant,
  output logic [31:0]           arb_pkt_cnt,
  output logic                  arb_proto_err
);

  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MOD_W  = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {IDLE, XFER} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               first_q, first_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [MOD_W-1:0]   mod_q, mod_d;
  logic               val_q, val_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int unsigned        idx;
  logic [DATA_W-1:0]  sel_data;
  logic [MOD_W-1:0]   sel_mod;
  logic               sel_val, sel_sop, sel_eop;
  logic               accept;

  assign cand       = src_tx_val & src_tx_sop;
  assign src_tx_rdy = (state_q == XFER && !pkt_tx_full) ? grant_q : '0;
  assign accept     = (state_q == XFER) && !pkt_tx_full && sel_val;

  // Round-robin search upward from the source after the last grant
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!win_found && cand[IDX_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  // Beat of the granted source
  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_q[i]) begin
        sel_data = src_tx_data[i*DATA_W +: DATA_W];
        sel_mod  = src_tx_mod[i*MOD_W +: MOD_W];
        sel_val  = src_tx_val[i];
        sel_sop  = src_tx_sop[i];
        sel_eop  = src_tx_eop[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    first_d = first_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (|(src_tx_val & ~src_tx_sop)) err_d = 1'b1;
        if (win_found) begin
          state_d = XFER;
          grant_d = NUM_SRC'(1) << win_idx;
          last_d  = win_idx;
          first_d = 1'b1;
        end
      end
      XFER: begin
        if (accept) begin
          val_d   = 1'b1;
          sop_d   = sel_sop & first_q;
          eop_d   = sel_eop;
          data_d  = sel_data;
          mod_d   = sel_mod;
          first_d = 1'b0;
          // A repeated sop is flagged but the packet keeps flowing
          if (sel_sop && !first_q) err_d = 1'b1;
          if (sel_eop) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      first_q <= 1'b0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pkt_tx_data   = data_q;
  assign pkt_tx_mod    = mod_q;
  assign pkt_tx_val    = val_q;
  assign pkt_tx_sop    = sop_q;
  assign pkt_tx_eop    = eop_q;
  assign arb_grant     = grant_q;
  assign arb_pkt_cnt   = cnt_q;
  assign arb_proto_err = err_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Scoreboard bench for pkt_tx_arbiter: per-source packet queues, a packet-level reference
// model that predicts handshakes and delivered beats, and a monitor that checks pkt_tx_*.
module tb_pkt_tx_arbiter;

  localparam int N = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        start;
  } beat_t;

  logic            clk;
  logic            reset;
  logic [N*64-1:0] src_tx_data;
  logic [N-1:0]    src_tx_val, src_tx_sop, src_tx_eop, src_tx_rdy;
  logic [N*3-1:0]  src_tx_mod;
  logic [63:0]     pkt_tx_data;
  logic            pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full;
  logic [2:0]      pkt_tx_mod;
  logic [N-1:0]    arb_grant;
  logic [31:0]     arb_pkt_cnt;
  logic            arb_proto_err;

  pkt_tx_arbiter #(.NUM_SRC(N)) dut (
    .clk_156m25   (clk),
    .reset_156m25 (reset),
    .src_tx_data  (src_tx_data),
    .src_tx_val   (src_tx_val),
    .src_tx_sop   (src_tx_sop),
    .src_tx_eop   (src_tx_eop),
    .src_tx_mod   (src_tx_mod),
    .src_tx_rdy   (src_tx_rdy),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_full  (pkt_tx_full),
    .arb_grant    (arb_grant),
    .arb_pkt_cnt  (arb_pkt_cnt),
    .arb_proto_err(arb_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  beat_t       srcq [N][$];
  beat_t       expq[$];
  int          order_q[$];
  bit          full_seq[$];
  int          full_pct = 0;
  int          gap_pct  = 0;
  int          glitch_src = -1;
  int          pkt_seq = 0;
  bit          mon_en = 1'b0;
  bit          after_rst = 1'b0;
  logic [63:0] mon_last_data = '0;
  logic [2:0]  mon_last_mod = '0;

  // Reference model state: what the arbiter should hold after the last clock edge
  bit          m_busy, m_first, m_err;
  int          m_gnt, m_last;
  logic [31:0] m_cnt;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit pending();
    for (int s = 0; s < N; s++) if (srcq[s].size() != 0) return 1'b1;
    return expq.size() != 0;
  endfunction

  task automatic add_pkt(input int s, input int len, input logic [2:0] mod, input int err_beat);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {8'(s), 24'(pkt_seq), 32'($urandom)};
      b.sop   = (i == 0) || (i == err_beat);
      b.eop   = (i == len - 1);
      b.mod   = (i == len - 1) ? mod : 3'($urandom);
      b.start = (i == 0);
      srcq[s].push_back(b);
    end
    pkt_seq++;
  endtask

  task automatic step(input bit do_rst);
    logic [N-1:0]   v, sp, ep, rdy_exp, gnt_exp;
    logic [N*64-1:0] d;
    logic [N*3-1:0] md;
    bit             full_now, found;
    beat_t          b;
    int             g;
    @(negedge clk);
    if (full_seq.size() != 0) full_now = full_seq.pop_front();
    else full_now = ($urandom_range(0, 99) < full_pct);
    v = '0;
    for (int s = 0; s < N; s++) begin
      sp[s]         = 1'($urandom);
      ep[s]         = 1'($urandom);
      d[s*64 +: 64] = {$urandom, $urandom};
      md[s*3 +: 3]  = 3'($urandom);
      if (srcq[s].size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
        b             = srcq[s][0];
        v[s]          = 1'b1;
        sp[s]         = b.sop;
        ep[s]         = b.eop;
        d[s*64 +: 64] = b.data;
        md[s*3 +: 3]  = b.mod;
      end
    end
    if (glitch_src >= 0) begin
      v[glitch_src]  = 1'b1;
      sp[glitch_src] = 1'b0;
      glitch_src     = -1;
    end
    reset       = do_rst;
    src_tx_val  = v;
    src_tx_sop  = sp;
    src_tx_eop  = ep;
    src_tx_data = d;
    src_tx_mod  = md;
    pkt_tx_full = full_now;
    #1;
    if (after_rst) begin
      chk("rst_flags", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop}), 128'(0));
      chk("rst_data", 128'(pkt_tx_data), 128'(0));
      chk("rst_mod", 128'(pkt_tx_mod), 128'(0));
    end
    after_rst = do_rst;
    if (do_rst) begin
      m_busy = 1'b0; m_first = 1'b0; m_err = 1'b0; m_gnt = 0; m_last = N - 1; m_cnt = '0;
      for (int s = 0; s < N; s++)
        while (srcq[s].size() != 0 && !srcq[s][0].start) void'(srcq[s].pop_front());
      mon_last_data = '0;
      mon_last_mod  = '0;
      mon_en        = 1'b1;
      return;
    end
    rdy_exp = '0;
    gnt_exp = '0;
    if (m_busy) gnt_exp[m_gnt] = 1'b1;
    if (m_busy && !full_now) rdy_exp[m_gnt] = 1'b1;
    chk("rdy", 128'(src_tx_rdy), 128'(rdy_exp));
    chk("grant", 128'(arb_grant), 128'(gnt_exp));
    chk("pkt_cnt", 128'(arb_pkt_cnt), 128'(m_cnt));
    chk("proto_err", 128'(arb_proto_err), 128'(m_err));
    if (!m_busy) begin
      if ((v & ~sp) != '0) m_err = 1'b1;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        g = (m_last + k) % N;
        if (!found && v[g] && sp[g]) begin
          found = 1'b1; m_busy = 1'b1; m_gnt = g; m_last = g; m_first = 1'b1;
        end
      end
    end else if (rdy_exp[m_gnt] && v[m_gnt]) begin
      b = srcq[m_gnt].pop_front();
      if (b.sop && !m_first) m_err = 1'b1;
      b.sop   = b.sop & m_first;
      b.start = 1'b0;
      m_first = 1'b0;
      expq.push_back(b);
      if (b.eop) begin
        m_cnt  = m_cnt + 32'd1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step(1'b0);
      n++;
    end
    chk("drain_done", 128'(pending()), 128'(0));
  endtask

  // Monitor: every delivered beat must be the next one the model predicted, one cycle after acceptance
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pkt_tx_val === 1'b1) begin
          chk("beat_due", 128'(expq.size() != 0), 128'(1));
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("beat", 128'({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                128'({e.data, e.sop, e.eop, e.mod}));
          end
          if (pkt_tx_sop === 1'b1) order_q.push_back(int'(pkt_tx_data[63:56]));
          mon_last_data = pkt_tx_data;
          mon_last_mod  = pkt_tx_mod;
        end else begin
          chk("no_beat_due", 128'(expq.size()), 128'(0));
          chk("idle_sop_eop", 128'({pkt_tx_sop, pkt_tx_eop}), 128'(0));
          chk("hold_data", 128'(pkt_tx_data), 128'(mon_last_data));
          chk("hold_mod", 128'(pkt_tx_mod), 128'(mon_last_mod));
        end
      end
    end
  end

  initial begin
    int n, s, len, eb;
    reset = 1'b1; pkt_tx_full = 1'b0;
    src_tx_val = '0; src_tx_sop = '0; src_tx_eop = '0; src_tx_data = '0; src_tx_mod = '0;
    step(1'b1);

    // Single 4-beat packet from source 0
    add_pkt(0, 4, 3'd5, -1);
    drain(50);
    chk("t1_cnt", 128'(arb_pkt_cnt), 128'(1));
    chk("t1_err", 128'(arb_proto_err), 128'(0));

    // Two sources contending with 2-beat packets
    step(1'b1);
    order_q.delete();
    for (int i = 0; i < 2; i++) begin
      add_pkt(0, 2, 3'd1, -1);
      add_pkt(1, 2, 3'd2, -1);
    end
    drain(60);
    chk("t2_order_n", 128'(order_q.size()), 128'(4));
    if (order_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_order", 128'(order_q[i]), 128'(i % 2));
    chk("t2_cnt", 128'(arb_pkt_cnt), 128'(4));

    // Three cycles of backpressure mid-packet
    add_pkt(0, 8, 3'd3, -1);
    full_seq = '{0, 0, 0, 1, 1, 1};
    drain(60);

    // Back-to-back single-beat packets from source 1
    for (int i = 0; i < 4; i++) add_pkt(1, 1, 3'd7, -1);
    drain(60);

    // Repeated sop on the third beat
    add_pkt(0, 5, 3'd4, 2);
    drain(60);
    chk("t5_err", 128'(arb_proto_err), 128'(1));
    add_pkt(1, 3, 3'd0, -1);
    drain(60);
    chk("t5_err_sticky", 128'(arb_proto_err), 128'(1));

    // Reset while the second beat is presented
    step(1'b1);
    add_pkt(0, 5, 3'd6, -1);
    n = 0;
    while (srcq[0].size() != 4 && n < 20) begin
      step(1'b0);
      n++;
    end
    chk("t6_beat1_taken", 128'(srcq[0].size()), 128'(4));
    step(1'b1);
    add_pkt(0, 3, 3'd2, -1);
    drain(60);
    chk("t6_cnt", 128'(arb_pkt_cnt), 128'(1));

    // Non-sop request while idle
    glitch_src = 1;
    step(1'b0);
    step(1'b0);
    chk("t7_err", 128'(arb_proto_err), 128'(1));

    // Randomized traffic with gaps, backpressure and occasional repeated sop
    step(1'b1);
    gap_pct  = 20;
    full_pct = 25;
    for (int i = 0; i < 40; i++) begin
      s   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 6);
      eb  = (len > 2 && $urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : -1;
      add_pkt(s, len, 3'($urandom), eb);
    end
    drain(4000);
    chk("t8_cnt", 128'(arb_pkt_cnt), 128'(40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
